// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory ctrl codes, FSM states,
// access-size decode helpers.
package load_store_unit_pkg;

    localparam int CTRL_MEM_WIDTH  = 4;
    localparam int LSU_STATE_WIDTH = 3;

    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_NONE = 4'd0;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LB   = 4'd1;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LH   = 4'd2;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LW   = 4'd3;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LBU  = 4'd4;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LHU  = 4'd5;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SB   = 4'd6;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SH   = 4'd7;
    localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SW   = 4'd8;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WB       = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Unknown non-zero codes fall back to a word access.
    function automatic mem_size_e ctrl_size(input logic [CTRL_MEM_WIDTH-1:0] ctrl);
        case (ctrl)
            CTRL_LB, CTRL_LBU, CTRL_SB: return SZ_BYTE;
            CTRL_LH, CTRL_LHU, CTRL_SH: return SZ_HALF;
            default:                    return SZ_WORD;
        endcase
    endfunction

    function automatic logic ctrl_signed(input logic [CTRL_MEM_WIDTH-1:0] ctrl);
        return (ctrl == CTRL_LB) || (ctrl == CTRL_LH);
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: picks the addressed byte/half out of the returned word
// and sign- or zero-extends it according to the load ctrl code.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [CTRL_MEM_WIDTH-1:0] ctrl,
    input  logic [1:0]                lane,
    input  logic [31:0]               rdata,
    output logic [31:0]               data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = rdata[{lane[1], 4'b0000} +: 16];
        sext     = ctrl_signed(ctrl);
        case (ctrl_size(ctrl))
            SZ_BYTE: data = {{24{sext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: EA calc, dmem request/response handshake,
// load writeback, flush. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uop_valid_in,
    input  logic                      uop_is_mem_load,
    input  logic                      uop_is_mem_store,
    input  logic [CTRL_MEM_WIDTH-1:0] ctrl_mem,
    input  logic [31:0]               rs1_data,
    input  logic [31:0]               imm,
    input  logic [31:0]               rs2_data,
    input  logic [4:0]                rd_addr,
    input  logic                      flush,
    output logic                      lsu_ready,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic                      dmem_we,
    output logic [DATA_WIDTH/8-1:0]   dmem_wstrb,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_rsp_rdata,
    output logic                      wb_valid,
    output logic [4:0]                wb_rd,
    output logic [31:0]               wb_data,
    output logic                      misalign_exc,
    output logic [ADDR_WIDTH-1:0]     exc_addr
);

    lsu_state_e                state;
    logic [CTRL_MEM_WIDTH-1:0] ctrl_q;
    logic [1:0]                lane_q;
    logic                      is_load_q;

    logic                      accept;
    logic [31:0]               sum;
    logic [ADDR_WIDTH-1:0]     ea_acc;
    logic                      mis_acc;
    mem_size_e                 size_acc;
    logic [DATA_WIDTH/8-1:0]   strb_acc;
    logic [DATA_WIDTH-1:0]     wdata_acc;
    logic [31:0]               align_data;

    assign lsu_ready = (state == ST_IDLE);
    assign accept    = (state == ST_IDLE) && uop_valid_in
                     && (uop_is_mem_load || uop_is_mem_store) && (ctrl_mem != CTRL_NONE);

    always_comb begin
        sum       = rs1_data + imm;
        ea_acc    = sum[ADDR_WIDTH-1:0];
        size_acc  = ctrl_size(ctrl_mem);
        mis_acc   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (size_acc)
            SZ_HALF: mis_acc = ea_acc[0];
            SZ_WORD: mis_acc = |ea_acc[1:0];
            default: mis_acc = 1'b0;
        endcase
`else
        // Without the trap, silently round down to natural alignment.
        case (size_acc)
            SZ_HALF: ea_acc[0]   = 1'b0;
            SZ_WORD: ea_acc[1:0] = 2'b00;
            default: ;
        endcase
`endif
        strb_acc  = '0;
        wdata_acc = '0;
        if (!uop_is_mem_load) begin
            case (size_acc)
                SZ_BYTE: begin
                    strb_acc  = 4'b0001 << ea_acc[1:0];
                    wdata_acc = {4{rs2_data[7:0]}};
                end
                SZ_HALF: begin
                    strb_acc  = 4'b0011 << {ea_acc[1], 1'b0};
                    wdata_acc = {2{rs2_data[15:0]}};
                end
                default: begin
                    strb_acc  = 4'b1111;
                    wdata_acc = rs2_data;
                end
            endcase
        end
    end

    lsu_load_align u_align (
        .ctrl  (ctrl_q),
        .lane  (lane_q),
        .rdata (dmem_rsp_rdata),
        .data  (align_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    // Pulse lands in the REQ cycle of the faulting uop; the FSM uses it to skip the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_exc <= 1'b0;
            exc_addr     <= '0;
        end else begin
            misalign_exc <= accept && mis_acc;
            if (accept && mis_acc)
                exc_addr <= ea_acc;
        end
    end
`else
    assign misalign_exc = 1'b0;
    assign exc_addr     = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            ctrl_q         <= CTRL_NONE;
            lane_q         <= 2'b00;
            is_load_q      <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= '0;
            dmem_we        <= 1'b0;
            dmem_wstrb     <= '0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state          <= ST_REQ;
                        ctrl_q         <= ctrl_mem;
                        lane_q         <= ea_acc[1:0];
                        is_load_q      <= uop_is_mem_load;
                        dmem_req_valid <= !mis_acc;
                        dmem_addr      <= {ea_acc[ADDR_WIDTH-1:2], 2'b00};
                        dmem_we        <= !uop_is_mem_load;
                        dmem_wstrb     <= strb_acc;
                        dmem_wdata     <= wdata_acc;
                        if (uop_is_mem_load)
                            wb_rd <= rd_addr;
                    end
                end
                ST_REQ: begin
                    if (misalign_exc) begin
                        state <= ST_IDLE;
                    end else if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (!is_load_q)
                            state <= ST_IDLE;
                        else if (flush)
                            state <= ST_DRAIN;
                        else
                            state <= ST_WAIT_RSP;
                    end else if (flush) begin
                        dmem_req_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                ST_WAIT_RSP: begin
                    // A response arriving alongside flush is already consumed; no drain needed.
                    if (flush)
                        state <= dmem_rsp_valid ? ST_IDLE : ST_DRAIN;
                    else if (dmem_rsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= align_data;
                        state    <= ST_WB;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_rsp_valid)
                        state <= ST_IDLE;
                end
                ST_WB: begin
                    wb_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// uops checked against an arithmetic reference model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uop_valid_in = 1'b0, uop_is_mem_load = 1'b0, uop_is_mem_store = 1'b0;
    logic [3:0]  ctrl_mem = '0;
    logic [31:0] rs1_data = '0, imm = '0, rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        lsu_ready, dmem_req_valid, dmem_we, wb_valid, misalign_exc;
    logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, wb_data, exc_addr;
    logic [31:0] dmem_rsp_rdata = '0;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    int tests = 0;
    int fails = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .uop_valid_in(uop_valid_in),
        .uop_is_mem_load(uop_is_mem_load), .uop_is_mem_store(uop_is_mem_store),
        .ctrl_mem(ctrl_mem), .rs1_data(rs1_data), .imm(imm), .rs2_data(rs2_data),
        .rd_addr(rd_addr), .flush(flush), .lsu_ready(lsu_ready),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_rdata(dmem_rsp_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_exc(misalign_exc), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [3:0] c);
        if (c == CTRL_LB || c == CTRL_LBU || c == CTRL_SB) return 1;
        if (c == CTRL_LH || c == CTRL_LHU || c == CTRL_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_ea(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        e = a + b;
`ifndef LSU_MISALIGN_TRAP_EN
        e = e - (e % m_size(c));
`endif
        return e;
    endfunction

    function automatic bit m_mis(input logic [3:0] c, input logic [31:0] e);
`ifdef LSU_MISALIGN_TRAP_EN
        return (e % m_size(c)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] c, input logic [31:0] e);
        int s;
        s = m_size(c);
        return 4'(((1 << s) - 1) << (e % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] c, input logic [31:0] d);
        case (m_size(c))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] c, input logic [31:0] e, input logic [31:0] rd);
        longint v, one;
        int s;
        one = 1;
        s = m_size(c);
        if (s == 4) return rd;
        v = longint'(rd >> (8 * (e % 4))) & ((one << (8 * s)) - 1);
        if ((c == CTRL_LB || c == CTRL_LH) && v >= (one << (8 * s - 1)))
            v = v - (one << (8 * s));
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_uop(input bit ld, input bit st, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] d, input logic [4:0] rd);
        uop_valid_in = 1'b1; uop_is_mem_load = ld; uop_is_mem_store = st;
        ctrl_mem = c; rs1_data = a; imm = b; rs2_data = d; rd_addr = rd;
        step();
        uop_valid_in = 1'b0; uop_is_mem_load = 1'b0; uop_is_mem_store = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        tests++; if ({lsu_ready, dmem_req_valid, dmem_we, wb_valid, misalign_exc} !== 5'b10000) begin fails++; $display("FAIL reset_ctrl: got %b want 10000", {lsu_ready, dmem_req_valid, dmem_we, wb_valid, misalign_exc}); end
        tests++; if ({dmem_addr, dmem_wstrb, dmem_wdata, wb_rd, wb_data, exc_addr} !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", {dmem_addr, dmem_wstrb, dmem_wdata, wb_rd, wb_data, exc_addr}); end
        @(negedge clk) reset = 1'b1;
        step();
    endtask

    task automatic test_ignore();
        dmem_req_ready = 1'b1;
        drive_uop(1'b1, 1'b0, CTRL_NONE, 32'h100, 32'h0, 32'h0, 5'd1);
        tests++; if ({lsu_ready, dmem_req_valid} !== 2'b10) begin fails++; $display("FAIL zero_ctrl: got %b want 10", {lsu_ready, dmem_req_valid}); end
        drive_uop(1'b0, 1'b0, CTRL_LW, 32'h100, 32'h0, 32'h0, 5'd1);
        tests++; if ({lsu_ready, dmem_req_valid} !== 2'b10) begin fails++; $display("FAIL no_flag: got %b want 10", {lsu_ready, dmem_req_valid}); end
    endtask

    task automatic test_lw();
        dmem_req_ready = 1'b1;
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h1000, 32'h4, 32'h0, 5'd9);
        tests++; if ({dmem_req_valid, dmem_we, dmem_wstrb} !== 6'b100000) begin fails++; $display("FAIL lw_req: got %b want 100000", {dmem_req_valid, dmem_we, dmem_wstrb}); end
        tests++; if (dmem_addr !== 32'h1004) begin fails++; $display("FAIL lw_addr: got %h want 00001004", dmem_addr); end
        step();
        tests++; if ({dmem_req_valid, wb_valid, lsu_ready} !== 3'b000) begin fails++; $display("FAIL lw_wait: got %b want 000", {dmem_req_valid, wb_valid, lsu_ready}); end
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hDEADBEEF;
        step();
        dmem_rsp_valid = 1'b0;
        tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin fails++; $display("FAIL lw_wb: got %b/%0d/%h want 1/9/deadbeef", wb_valid, wb_rd, wb_data); end
        step();
        tests++; if ({wb_valid, lsu_ready} !== 2'b01) begin fails++; $display("FAIL lw_done: got %b want 01", {wb_valid, lsu_ready}); end
    endtask

    task automatic test_lb_lbu();
        logic [3:0]  cs [2];
        logic [31:0] ex [2];
        cs[0] = CTRL_LB;  ex[0] = 32'hFFFFFF80;
        cs[1] = CTRL_LBU; ex[1] = 32'h00000080;
        dmem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_uop(1'b1, 1'b0, cs[i], 32'h1000, 32'h3, 32'h0, 5'd3);
            step();
            dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h80FFFF7F;
            step();
            dmem_rsp_valid = 1'b0;
            tests++; if ({wb_valid, wb_data} !== {1'b1, ex[i]}) begin fails++; $display("FAIL lb_ext%0d: got %b/%h want 1/%h", i, wb_valid, wb_data, ex[i]); end
            step();
        end
    endtask

    task automatic test_sh_stall();
        dmem_req_ready = 1'b0;
        drive_uop(1'b0, 1'b1, CTRL_SH, 32'h2000, 32'h2, 32'h1234ABCD, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tests++; if ({dmem_req_valid, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata} !== {2'b11, 4'b1100, 32'h2000, 32'hABCDABCD}) begin fails++; $display("FAIL sh_hold%0d: got %b %b %b %h %h", i, dmem_req_valid, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata); end
            step();
        end
        dmem_req_ready = 1'b1;
        step();
        tests++; if ({lsu_ready, dmem_req_valid} !== 2'b10) begin fails++; $display("FAIL sh_done: got %b want 10", {lsu_ready, dmem_req_valid}); end
    endtask

    task automatic test_back_to_back();
        dmem_req_ready = 1'b1;
        drive_uop(1'b0, 1'b1, CTRL_SB, 32'h3001, 32'h0, 32'h000000A5, 5'd0);
        tests++; if ({dmem_req_valid, dmem_wstrb, dmem_wdata} !== {1'b1, 4'b0010, 32'hA5A5A5A5}) begin fails++; $display("FAIL b2b_sb: got %b %b %h", dmem_req_valid, dmem_wstrb, dmem_wdata); end
        step();
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", lsu_ready); end
        drive_uop(1'b0, 1'b1, CTRL_SW, 32'h3004, 32'h4, 32'hCAFEF00D, 5'd0);
        tests++; if ({dmem_req_valid, dmem_wstrb, dmem_addr, dmem_wdata} !== {1'b1, 4'b1111, 32'h3008, 32'hCAFEF00D}) begin fails++; $display("FAIL b2b_sw: got %b %b %h %h", dmem_req_valid, dmem_wstrb, dmem_addr, dmem_wdata); end
        step();
    endtask

    task automatic test_misalign();
        dmem_req_ready = 1'b1;
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h1000, 32'h1, 32'h0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        tests++; if ({misalign_exc, dmem_req_valid, lsu_ready, exc_addr} !== {3'b100, 32'h1001}) begin fails++; $display("FAIL mis_exc: got %b%b%b %h", misalign_exc, dmem_req_valid, lsu_ready, exc_addr); end
        step();
        tests++; if ({misalign_exc, dmem_req_valid, lsu_ready} !== 3'b001) begin fails++; $display("FAIL mis_done: got %b want 001", {misalign_exc, dmem_req_valid, lsu_ready}); end
`else
        tests++; if ({misalign_exc, dmem_req_valid, dmem_addr, exc_addr} !== {2'b01, 32'h1000, 32'h0}) begin fails++; $display("FAIL mis_req: got %b%b %h %h", misalign_exc, dmem_req_valid, dmem_addr, exc_addr); end
        step();
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h11223344;
        step();
        dmem_rsp_valid = 1'b0;
        tests++; if ({wb_valid, wb_data} !== {1'b1, 32'h11223344}) begin fails++; $display("FAIL mis_wb: got %b %h", wb_valid, wb_data); end
        step();
`endif
    endtask

    task automatic test_flush();
        // Flush while the request is still pending.
        dmem_req_ready = 1'b0;
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h4000, 32'h0, 32'h0, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if ({dmem_req_valid, lsu_ready} !== 2'b01) begin fails++; $display("FAIL flush_req: got %b want 01", {dmem_req_valid, lsu_ready}); end
        // Flush in WAIT_RSP with response two cycles late.
        dmem_req_ready = 1'b1;
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h4000, 32'h0, 32'h0, 5'd2);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        tests++; if ({lsu_ready, wb_valid} !== 2'b00) begin fails++; $display("FAIL flush_drain: got %b want 00", {lsu_ready, wb_valid}); end
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h55555555;
        step();
        dmem_rsp_valid = 1'b0;
        tests++; if ({lsu_ready, wb_valid} !== 2'b10) begin fails++; $display("FAIL flush_wait: got %b want 10", {lsu_ready, wb_valid}); end
        // Flush coinciding with the request handshake.
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h4000, 32'h0, 32'h0, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if ({lsu_ready, dmem_req_valid} !== 2'b00) begin fails++; $display("FAIL flush_hs: got %b want 00", {lsu_ready, dmem_req_valid}); end
        dmem_rsp_valid = 1'b1;
        step();
        dmem_rsp_valid = 1'b0;
        tests++; if ({lsu_ready, wb_valid} !== 2'b10) begin fails++; $display("FAIL flush_hs_done: got %b want 10", {lsu_ready, wb_valid}); end
    endtask

    task automatic test_async_reset();
        dmem_req_ready = 1'b1;
        drive_uop(1'b1, 1'b0, CTRL_LW, 32'h5004, 32'h0, 32'h0, 5'd7);
        step();
        #2 reset = 1'b0;
        #1;
        tests++; if ({lsu_ready, dmem_req_valid, dmem_we, wb_valid, misalign_exc} !== 5'b10000) begin fails++; $display("FAIL areset_ctrl: got %b want 10000", {lsu_ready, dmem_req_valid, dmem_we, wb_valid, misalign_exc}); end
        tests++; if ({dmem_addr, dmem_wstrb, dmem_wdata, wb_rd, wb_data, exc_addr} !== '0) begin fails++; $display("FAIL areset_data: got %h want 0", {dmem_addr, dmem_wstrb, dmem_wdata, wb_rd, wb_data, exc_addr}); end
        @(negedge clk) reset = 1'b1;
        step();
        tests++; if ({lsu_ready, dmem_req_valid, wb_valid} !== 3'b100) begin fails++; $display("FAIL areset_rel: got %b want 100", {lsu_ready, dmem_req_valid, wb_valid}); end
    endtask

    task automatic test_random();
        logic [3:0]  ops [8];
        logic [3:0]  c;
        logic [31:0] a, b, d, e, rdv;
        logic [4:0]  rd;
        bit          ld, st;
        int          k, rw, pw;
        ops = '{CTRL_LB, CTRL_LH, CTRL_LW, CTRL_LBU, CTRL_LHU, CTRL_SB, CTRL_SH, CTRL_SW};
        for (int it = 0; it < 60; it++) begin
            k  = int'($urandom_range(0, 7));
            c  = ops[k];
            ld = (k < 5);
            st = ld ? bit'($urandom_range(0, 1)) : 1'b1;
            a  = $urandom; b = $urandom; d = $urandom; rd = 5'($urandom);
            rw = int'($urandom_range(0, 2)); pw = int'($urandom_range(0, 2));
            e  = m_ea(c, a, b);
            dmem_req_ready = 1'b0;
            drive_uop(ld, st, c, a, b, d, rd);
            if (m_mis(c, e)) begin
                tests++; if ({misalign_exc, dmem_req_valid, exc_addr} !== {2'b10, e}) begin fails++; $display("FAIL rnd%0d_mis: got %b%b %h want 10 %h", it, misalign_exc, dmem_req_valid, exc_addr, e); end
                step();
                tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL rnd%0d_misrdy: got %b want 1", it, lsu_ready); end
                continue;
            end
            tests++; if ({dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb} !== {1'b1, !ld, e & 32'hFFFFFFFC, ld ? 4'b0000 : m_strb(c, e)}) begin fails++; $display("FAIL rnd%0d_req: got %b%b %h %b ea %h", it, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, e); end
            if (!ld) begin
                tests++; if (dmem_wdata !== m_wdata(c, d)) begin fails++; $display("FAIL rnd%0d_wdata: got %h want %h", it, dmem_wdata, m_wdata(c, d)); end
            end
            for (int w = 0; w < rw; w++) step();
            tests++; if ({dmem_req_valid, dmem_addr} !== {1'b1, e & 32'hFFFFFFFC}) begin fails++; $display("FAIL rnd%0d_hold: got %b %h", it, dmem_req_valid, dmem_addr); end
            dmem_req_ready = 1'b1;
            step();
            dmem_req_ready = 1'b0;
            if (!ld) begin
                tests++; if ({lsu_ready, dmem_req_valid} !== 2'b10) begin fails++; $display("FAIL rnd%0d_st_done: got %b want 10", it, {lsu_ready, dmem_req_valid}); end
                continue;
            end
            for (int w = 0; w < pw; w++) step();
            tests++; if ({wb_valid, lsu_ready, dmem_req_valid} !== 3'b000) begin fails++; $display("FAIL rnd%0d_wait: got %b want 000", it, {wb_valid, lsu_ready, dmem_req_valid}); end
            rdv = $urandom;
            dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdv;
            step();
            dmem_rsp_valid = 1'b0;
            tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, rd, m_load(c, e, rdv)}) begin fails++; $display("FAIL rnd%0d_wb: got %b %0d %h want 1 %0d %h", it, wb_valid, wb_rd, wb_data, rd, m_load(c, e, rdv)); end
            step();
            tests++; if ({wb_valid, lsu_ready} !== 2'b01) begin fails++; $display("FAIL rnd%0d_ld_done: got %b want 01", it, {wb_valid, lsu_ready}); end
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_lw();
        test_lb_lbu();
        test_sh_stall();
        test_back_to_back();
        test_misalign();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
